carry_chain_counter: RTL



---
 rtl/carry_chain_counter_pkg.sv | 32 +++
 rtl/adder_carry.sv | 14 +
 rtl/carry_chain_incdec.sv | 29 ++
 rtl/carry_chain_counter.sv | 68 ++++++
 4 files changed

// File: rtl/carry_chain_counter_pkg.sv
// Shared definitions for the carry-chain counter.
// Boundary-mode encodings and control-priority decoding.
package carry_chain_counter_pkg;

    localparam bit SATURATE_WRAP = 1'b0;
    localparam bit SATURATE_HOLD = 1'b1;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_CLEAR,
        OP_LOAD,
        OP_COUNT
    } op_e;

    // Clear beats load beats count; lower-priority inputs are never looked at
    function automatic op_e decode_op(
        input logic clr,
        input logic l,
        input logic e
    );
        if (clr) begin
            return OP_CLEAR;
        end else if (l) begin
            return OP_LOAD;
        end else if (e) begin
            return OP_COUNT;
        end else begin
            return OP_HOLD;
        end
    endfunction

endpackage

// File: rtl/adder_carry.sv
// Single carry-chain cell: propagate/generate full-adder slice.
// sumout = p ^ cin, cout = p ? cin : g.
module adder_carry (
    input  logic p,
    input  logic g,
    input  logic cin,
    output logic sumout,
    output logic cout
);

    assign sumout = p ^ cin;
    assign cout   = p ? cin : g;

endmodule

// File: rtl/carry_chain_incdec.sv
// Ripple incrementer/decrementer built from adder_carry cells, LSB first.
// cout is the MSB carry; it marks all-ones going up and non-zero going down.
module carry_chain_incdec #(
    parameter int WIDTH = 8
) (
    input  logic             up,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    // Increment adds 1 through cin; decrement adds all-ones with cin=0
    assign carry[0] = up;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        adder_carry u_cell (
            .p      (up ? q[i] : ~q[i]),
            .g      (~up & q[i]),
            .cin    (carry[i]),
            .sumout (sum[i]),
            .cout   (carry[i+1])
        );
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/carry_chain_counter.sv
// Up/down counter mapped onto the carry chain, with load, clear,
// wrap/saturate boundary handling, terminal count and sticky overflow.
module carry_chain_counter
    import carry_chain_counter_pkg::*;
#(
    parameter int             WIDTH    = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter bit             SATURATE = SATURATE_WRAP
) (
    input  logic             C,
    input  logic             R,
    input  logic             CLR,
    input  logic             L,
    input  logic [WIDTH-1:0] D,
    input  logic             E,
    input  logic             UP,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             OV
);

    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             boundary;
    op_e              op;

    carry_chain_incdec #(
        .WIDTH (WIDTH)
    ) u_incdec (
        .up   (UP),
        .q    (Q),
        .sum  (sum),
        .cout (cout)
    );

    assign boundary = UP ? cout : ~cout;
    assign op       = decode_op(CLR, L, E);
    assign TC       = (op == OP_COUNT) & boundary;

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            Q  <= RST_VAL;
            OV <= 1'b0;
        end else begin
            unique case (op)
                OP_CLEAR: begin
                    Q  <= RST_VAL;
                    OV <= 1'b0;
                end
                OP_LOAD: begin
                    Q <= D;
                end
                OP_COUNT: begin
                    if (boundary) begin
                        OV <= 1'b1;
                    end
                    // The carry-chain sum already is the wrapped value
                    if (!(boundary && SATURATE == SATURATE_HOLD)) begin
                        Q <= sum;
                    end
                end
                OP_HOLD: begin
                end
            endcase
        end
    end

endmodule
